alu_pa_low_select_arbiter: RTL and testbench
============================================

// Module: alu_pa_low_select_arbiter
// PURPOSE
//  Arbitrates and sequences the ALU port-A low-byte source selects: R, I, and I-as-IOP-high-byte.
//  Three requesters (reg path R, immediate path I, I/O-port path IOP) compete; one owner at a time.
//  Drives the mux selects with guaranteed break-before-make (dead cycles) and optional preemption.
//  Sits next to the input mux on the register board, clocked by the CPU core clock.
// PARAMETERS
//  DEAD_CYCLES  1   cycles with all selects inactive between owners; legal range 1..7
//  MAX_HOLD     8   max OWN cycles while another req pends; 0 = never preempt; range 0..255
// PORTS
//  CLK                 in   1  core clock, rising edge
//  notRST              in   1  asynchronous active-low reset
//  req_R               in   1  R path requests port-A low byte (level, held until done)
//  req_I               in   1  I path requests port-A low byte (level)
//  req_IOP             in   1  IOP path requests I on high byte (level)
//  notPA_Select_R_low  out  1  active-low select R; registered
//  notPA_Select_I_low  out  1  active-low select I; registered
//  PA_Select_IOP_low   out  1  active-high select IOP; registered
//  gnt_R/gnt_I/gnt_IOP out  1  each: owner's mux select is driving this cycle
//  busy                out  1  1 in any state other than IDLE
//  owner               out  2  0 none, 1 R, 2 I, 3 IOP
// BEHAVIOUR
//  - Reset (async, notRST=0): notPA_Select_R_low=1, notPA_Select_I_low=1, PA_Select_IOP_low=0,
//    all gnt=0, busy=0, owner=0, state IDLE, counters 0. Selects drop same instant, not next edge.
//  - States: IDLE -> OWN -> GAP -> (OWN | IDLE).
//  - IDLE: on edge with any req high, latch winner; OWN from next cycle (latency 1 edge).
//  - OWN: exactly one select active and matching gnt=1; hold_cnt increments each cycle (saturates).
//    Owner req low at edge -> GAP. Preempt: MAX_HOLD!=0, hold_cnt==MAX_HOLD, other req high -> GAP.
//  - GAP: all selects inactive, gnt=0, busy=1; lasts DEAD_CYCLES cycles; on last GAP cycle
//    arbitrate: any req -> OWN next cycle, else IDLE. Owner->owner handoff never skips GAP.
//  - Arbitration: fixed priority IOP > I > R. Preempted owner keeps req high and re-arbitrates.
//  - Simultaneous owner release and new req: GAP first, then new owner.
//  - Owner req drops and reasserts within GAP: treated as new request, normal arbitration.
//  - Invariant: at most one of {!notPA_Select_R_low, !notPA_Select_I_low, PA_Select_IOP_low}
//    true in any cycle, including reset entry/exit; gnt_x == select_x active.
//  - hold_cnt clears on entry to OWN; 8-bit, saturating at 255.
//  - owner holds last winner during OWN, 0 in IDLE and GAP.
// CONFIGURATION
//  NORZ_PA_ARB_RR_EN defined: round-robin; last owner becomes lowest priority, rotation
//    order R -> I -> IOP -> R; pointer resets to R lowest (IOP first after reset).
//  Not defined: fixed priority IOP > I > R; no rotation state synthesized.
// TESTING
//  1 Reset, req_I=1 at edge 0 -> notPA_Select_I_low=0, gnt_I=1, owner=2 from cycle 1; others idle.
//  2 Owner I, drop req_I and raise req_R same edge -> 1 GAP cycle (all inactive), R owns cycle 2.
//  3 All three req at once, fixed prio -> IOP, then I, then R, each separated by DEAD_CYCLES gaps.
//  4 MAX_HOLD=8, R held, req_I at cycle 3 -> R preempted after 8 OWN cycles, GAP, I owns.
//  5 notRST low mid-OWN (async, between edges) -> selects inactive immediately, owner=0, busy=0.
//  6 NORZ_PA_ARB_RR_EN, all req held, MAX_HOLD=2 -> owners rotate IOP,R,I,IOP; one-hot never broken.

Source files
------------

// File: rtl/alu_pa_low_select_arbiter.sv
// Port-A low-byte source select arbiter: R / I / IOP requesters, one owner, dead cycles between owners.
// Optional round-robin arbitration is enabled by defining NORZ_PA_ARB_RR_EN.
module alu_pa_low_select_arbiter #(
  parameter int unsigned DEAD_CYCLES = 1,
  parameter int unsigned MAX_HOLD    = 8
) (
  input  logic       CLK,
  input  logic       notRST,
  input  logic       req_R,
  input  logic       req_I,
  input  logic       req_IOP,
  output logic       notPA_Select_R_low,
  output logic       notPA_Select_I_low,
  output logic       PA_Select_IOP_low,
  output logic       gnt_R,
  output logic       gnt_I,
  output logic       gnt_IOP,
  output logic       busy,
  output logic [1:0] owner,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_R    = 2'd1;
  localparam logic [1:0] OWN_I    = 2'd2;
  localparam logic [1:0] OWN_IOP  = 2'd3;

  localparam logic [2:0] GAP_LAST   = 3'(DEAD_CYCLES - 1);
  // hold_cnt counts OWN cycles already completed, so the current cycle is hold_cnt+1.
  localparam logic [7:0] HOLD_LIMIT = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_t     state;
  logic [7:0] hold_cnt;
  logic [2:0] gap_cnt;
  logic [3:0] req_vec;
  logic [1:0] winner;
  logic       owner_req;
  logic       other_req;
  logic       preempt;
  logic       release_own;
  logic       take_grant;

  // Indexed by owner code; bit 0 (no owner) never requests.
  assign req_vec = {req_IOP, req_I, req_R, 1'b0};

  function automatic logic [1:0] pick(input logic [3:0] rv, input logic [1:0] p0,
                                      input logic [1:0] p1, input logic [1:0] p2);
    if (rv[p0])      pick = p0;
    else if (rv[p1]) pick = p1;
    else if (rv[p2]) pick = p2;
    else             pick = OWN_NONE;
  endfunction

`ifdef NORZ_PA_ARB_RR_EN
  logic [1:0] last_owner;

  // The owner after last_owner in R -> I -> IOP -> R order ranks highest; last_owner ranks lowest.
  always_comb begin
    winner = OWN_NONE;
    case (last_owner)
      OWN_R:   winner = pick(req_vec, OWN_I,   OWN_IOP, OWN_R);
      OWN_I:   winner = pick(req_vec, OWN_IOP, OWN_R,   OWN_I);
      OWN_IOP: winner = pick(req_vec, OWN_R,   OWN_I,   OWN_IOP);
      default: winner = pick(req_vec, OWN_IOP, OWN_I,   OWN_R);
    endcase
  end
`else
  always_comb begin
    winner = pick(req_vec, OWN_IOP, OWN_I, OWN_R);
  end
`endif

  assign owner_req   = req_vec[owner];
  assign other_req   = |(req_vec & ~(4'b0001 << owner));
  assign preempt     = (MAX_HOLD != 0) && (hold_cnt >= HOLD_LIMIT) && other_req;
  assign release_own = !owner_req || preempt;
  assign take_grant  = (winner != OWN_NONE) &&
                       ((state == ST_IDLE) || ((state == ST_GAP) && (gap_cnt == GAP_LAST)));

  always_ff @(posedge CLK or negedge notRST) begin
    if (!notRST) begin
      state              <= ST_IDLE;
      hold_cnt           <= '0;
      gap_cnt            <= '0;
      owner              <= OWN_NONE;
      notPA_Select_R_low <= 1'b1;
      notPA_Select_I_low <= 1'b1;
      PA_Select_IOP_low  <= 1'b0;
`ifdef NORZ_PA_ARB_RR_EN
      last_owner         <= OWN_NONE;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          gap_cnt <= '0;
        end
        ST_OWN: begin
          if (release_own) begin
            state              <= ST_GAP;
            gap_cnt            <= '0;
            owner              <= OWN_NONE;
            notPA_Select_R_low <= 1'b1;
            notPA_Select_I_low <= 1'b1;
            PA_Select_IOP_low  <= 1'b0;
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        ST_GAP: begin
          if (gap_cnt != GAP_LAST) begin
            gap_cnt <= gap_cnt + 3'd1;
          end else if (winner == OWN_NONE) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      // A grant from IDLE or the last GAP cycle overrides the state-local updates above.
      if (take_grant) begin
        state              <= ST_OWN;
        hold_cnt           <= '0;
        owner              <= winner;
        notPA_Select_R_low <= (winner != OWN_R);
        notPA_Select_I_low <= (winner != OWN_I);
        PA_Select_IOP_low  <= (winner == OWN_IOP);
`ifdef NORZ_PA_ARB_RR_EN
        last_owner         <= winner;
`endif
      end
    end
  end

  assign gnt_R     = ~notPA_Select_R_low;
  assign gnt_I     = ~notPA_Select_I_low;
  assign gnt_IOP   = PA_Select_IOP_low;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  a_sel_onehot: assert property (@(posedge CLK) disable iff (!notRST)
    $onehot0({~notPA_Select_R_low, ~notPA_Select_I_low, PA_Select_IOP_low}));

  a_gap_quiet: assert property (@(posedge CLK) disable iff (!notRST)
    (state != ST_OWN) |-> (notPA_Select_R_low && notPA_Select_I_low && !PA_Select_IOP_low));

endmodule

// File: tb/tb_alu_pa_low_select_arbiter.sv
// Self-checking bench: three arbiter configurations share one request stream and are compared
// every cycle against an ownership/gap-timeline model, plus hand-computed scenario expectations.
module tb_alu_pa_low_select_arbiter;

  localparam int N = 3;
  // Observation word: {notSelR, notSelI, selIOP, gntR, gntI, gntIOP, busy, owner[1:0]}
  localparam logic [8:0] OBS_RESET = 9'b110_000_0_00;
  localparam logic [8:0] OBS_I_OWN = 9'b100_010_1_10;
  localparam logic [8:0] OBS_GAP   = 9'b110_000_1_00;
  localparam logic [8:0] OBS_R_OWN = 9'b010_100_1_01;

  function automatic int dead_of(input int g);
    case (g)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int hold_of(input int g);
    case (g)
      0:       return 8;
      1:       return 0;
      default: return 2;
    endcase
  endfunction

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic req_r, req_i, req_iop;
  logic [8:0] obs [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic n_r, n_i, s_iop, g_r, g_i, g_iop, bsy;
    logic [1:0] own, dbg;
    alu_pa_low_select_arbiter #(
      .DEAD_CYCLES(dead_of(g)),
      .MAX_HOLD   (hold_of(g))
    ) u_dut (
      .CLK               (clk),
      .notRST            (rst_n),
      .req_R             (req_r),
      .req_I             (req_i),
      .req_IOP           (req_iop),
      .notPA_Select_R_low(n_r),
      .notPA_Select_I_low(n_i),
      .PA_Select_IOP_low (s_iop),
      .gnt_R             (g_r),
      .gnt_I             (g_i),
      .gnt_IOP           (g_iop),
      .busy              (bsy),
      .owner             (own),
      .dbg_state         (dbg)
    );
    assign obs[g] = {n_r, n_i, s_iop, g_r, g_i, g_iop, bsy, own};
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: current owner (0 none), OWN cycles so far including this one,
  // GAP cycles still to run, and the most recent owner (0 = none since reset).
  int m_owner   [N];
  int m_own_cyc [N];
  int m_gap_left[N];
  int m_last    [N];

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_owner[k] = 0; m_own_cyc[k] = 0; m_gap_left[k] = 0; m_last[k] = 0;
    end
  endtask

  function automatic int pick(input int last, input logic [3:0] rv);
    int order[3];
    order = '{3, 2, 1};
`ifdef NORZ_PA_ARB_RR_EN
    if (last != 0) begin
      order[0] = last % 3 + 1;
      order[1] = order[0] % 3 + 1;
      order[2] = last;
    end
`else
    if (last < 0) order = '{1, 2, 3};
`endif
    for (int i = 0; i < 3; i++) if (rv[order[i]]) return order[i];
    return 0;
  endfunction

  task automatic model_step();
    logic [3:0] rv;
    rv = {req_iop, req_i, req_r, 1'b0};
    for (int k = 0; k < N; k++) begin
      int  w;
      logic others;
      w = 0;
      if (m_owner[k] != 0) begin
        others = |(rv & ~(4'b0001 << m_owner[k]));
        if (!rv[m_owner[k]] ||
            (hold_of(k) != 0 && m_own_cyc[k] >= hold_of(k) && others)) begin
          m_owner[k]    = 0;
          m_gap_left[k] = dead_of(k);
        end else begin
          m_own_cyc[k]++;
        end
      end else if (m_gap_left[k] > 0) begin
        m_gap_left[k]--;
        if (m_gap_left[k] == 0) w = pick(m_last[k], rv);
      end else begin
        w = pick(m_last[k], rv);
      end
      if (w != 0) begin
        m_owner[k] = w; m_own_cyc[k] = 1; m_last[k] = w;
      end
    end
  endtask

  function automatic logic [8:0] exp_obs(input int k);
    int o;
    o = m_owner[k];
    return {o != 1, o != 2, o == 3, o == 1, o == 2, o == 3,
            (o != 0) || (m_gap_left[k] > 0), 2'(o)};
  endfunction

  task automatic check_all();
    for (int k = 0; k < N; k++) chk($sformatf("obs_inst%0d", k), 32'(obs[k]), 32'(exp_obs(k)));
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge: drive requests, let the DUT and model advance, compare at next fall.
  task automatic step(input logic [2:0] rv);
    req_r = rv[0]; req_i = rv[1]; req_iop = rv[2];
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < N; k++) chk($sformatf("%s_reset_inst%0d", tag, k), 32'(obs[k]), 32'(OBS_RESET));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int order_q[$];
    int prev;
    int r_cnt;
    logic [2:0] want;
    logic [2:0] rv;

    rst_n = 1'b0; req_r = 1'b0; req_i = 1'b0; req_iop = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) chk($sformatf("por_reset_inst%0d", k), 32'(obs[k]), 32'(OBS_RESET));
    rst_n = 1'b1;

    // I requests from idle: owns one edge later.
    step(3'b010);
    for (int k = 0; k < N; k++) chk($sformatf("i_first_inst%0d", k), 32'(obs[k]), 32'(OBS_I_OWN));
    // I releases while R requests: one dead cycle, then R.
    step(3'b001);
    chk("handoff_gap", 32'(obs[0]), 32'(OBS_GAP));
    step(3'b001);
    chk("handoff_r_owns", 32'(obs[0]), 32'(OBS_R_OWN));
    repeat (6) step(3'b000);

    // All three request at once; each drops after two OWN cycles on instance 0.
    want = 3'b111;
    prev = 0;
    for (int c = 0; c < 40; c++) begin
      step(want);
      if (m_owner[0] != 0 && prev == 0) order_q.push_back(m_owner[0]);
      prev = m_owner[0];
      if (m_owner[0] != 0 && m_own_cyc[0] >= 2) want[m_owner[0] - 1] = 1'b0;
    end
    chk("all3_grant_count", 32'(order_q.size()), 32'd3);
`ifdef NORZ_PA_ARB_RR_EN
    chk("all3_first",  32'(order_q[0]), 32'd2);
    chk("all3_second", 32'(order_q[1]), 32'd3);
    chk("all3_third",  32'(order_q[2]), 32'd1);
`else
    chk("all3_first",  32'(order_q[0]), 32'd3);
    chk("all3_second", 32'(order_q[1]), 32'd2);
    chk("all3_third",  32'(order_q[2]), 32'd1);
`endif
    repeat (6) step(3'b000);

    // R held, I joins on R's third OWN cycle: preempted after 8 cycles where MAX_HOLD is 8.
    step(3'b001);
    r_cnt = (m_owner[0] == 1) ? 1 : 0;
    for (int c = 1; c <= 12; c++) begin
      step((c >= 3) ? 3'b011 : 3'b001);
      if (m_owner[0] == 1) r_cnt++;
      if (c == 9) chk("preempt_i_owns", 32'(obs[0]), 32'(OBS_I_OWN));
    end
    chk("preempt_r_cycles", 32'(r_cnt), 32'd8);
    chk("no_preempt_hold0", 32'(obs[1]), 32'(OBS_R_OWN));
    repeat (8) step(3'b000);

    // Asynchronous reset in the middle of an IOP ownership.
    step(3'b100);
    step(3'b100);
    req_r = 1'b1; req_i = 1'b1;
    async_reset("mid_own");

    // All requests held from reset release on the MAX_HOLD=2 instance.
    order_q.delete();
    prev = 0;
    for (int c = 0; c < 24; c++) begin
      step(3'b111);
      if (m_owner[2] != 0 && prev == 0) order_q.push_back(m_owner[2]);
      prev = m_owner[2];
    end
    chk("rot_grant_count", 32'(order_q.size() >= 4), 32'd1);
`ifdef NORZ_PA_ARB_RR_EN
    chk("rot_0", 32'(order_q[0]), 32'd3);
    chk("rot_1", 32'(order_q[1]), 32'd1);
    chk("rot_2", 32'(order_q[2]), 32'd2);
    chk("rot_3", 32'(order_q[3]), 32'd3);
`else
    chk("rot_0", 32'(order_q[0]), 32'd3);
    chk("rot_1", 32'(order_q[1]), 32'd3);
    chk("rot_2", 32'(order_q[2]), 32'd3);
    chk("rot_3", 32'(order_q[3]), 32'd3);
`endif
    repeat (8) step(3'b000);

    // Random level requests with occasional toggles, one async reset midway.
    rv = 3'b000;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 5) == 0) rv[b] = ~rv[b];
      step(rv);
      if (c == 300) async_reset("random");
    end
    repeat (8) step(3'b000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
